// File: rtl/wb_intercon_pkg.sv
// wb_intercon_pkg: FSM state type and default bus geometry / address map for wb_intercon. Rev 1.0
`default_nettype none
package wb_intercon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  localparam int C_DEF_AW = 32;
  localparam int C_DEF_DW = 32;
  localparam int C_DEF_SW = 4;

  // Slot 0 sits in the least significant 32 bits.
  localparam logic [4*C_DEF_AW-1:0] C_DEF_SLAVE_BASE =
    {32'h0002_0000, 32'h0001_0100, 32'h0001_0000, 32'h0000_0000};
  localparam logic [4*C_DEF_AW-1:0] C_DEF_SLAVE_MASK =
    {32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_0000};

endpackage
`default_nettype wire

// File: rtl/wb_intercon_rr_arbiter.sv
// wb_rr_arbiter: combinational round-robin grant, search starts one past the last owner. Rev 1.0
`default_nettype none
module wb_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_grant
);

  // Walk from lowest to highest priority so the nearest requester wins.
  always_comb begin
    o_grant = '0;
    for (int k = N; k >= 1; k--) begin
      if (i_req[(int'(i_last) + k) % N]) begin
        o_grant = '0;
        o_grant[(int'(i_last) + k) % N] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_intercon.sv
// wb_intercon: N-master / M-slave shared-bus Wishbone interconnect with round-robin ownership. Rev 1.0
// Optional slave ack timeout enabled by defining WB_INTERCON_TIMEOUT_EN.
`default_nettype none
module wb_intercon
  import wb_intercon_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int NUM_SLAVES     = 4,
  parameter int WB_ADDR_WIDTH  = C_DEF_AW,
  parameter int WB_DATA_WIDTH  = C_DEF_DW,
  parameter int WB_SEL_WIDTH   = C_DEF_SW,
  parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_BASE = C_DEF_SLAVE_BASE,
  parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_MASK = C_DEF_SLAVE_MASK,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0] m_data_i,
  input  logic [NUM_MASTERS*WB_SEL_WIDTH-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]               m_we_i,
  input  logic [NUM_MASTERS-1:0]               m_stb_i,
  input  logic [NUM_MASTERS-1:0]               m_cyc_i,
  output logic [NUM_MASTERS-1:0]               m_ack_o,
  output logic [NUM_MASTERS-1:0]               m_err_o,
  output logic [NUM_MASTERS*WB_DATA_WIDTH-1:0] m_data_o,
  output logic [WB_ADDR_WIDTH-1:0]             s_addr_o,
  output logic [WB_DATA_WIDTH-1:0]             s_data_o,
  output logic [WB_SEL_WIDTH-1:0]              s_sel_o,
  output logic                                 s_we_o,
  output logic [NUM_SLAVES-1:0]                s_stb_o,
  output logic [NUM_SLAVES-1:0]                s_cyc_o,
  input  logic [NUM_SLAVES-1:0]                s_ack_i,
  input  logic [NUM_SLAVES*WB_DATA_WIDTH-1:0]  s_data_i,
  output logic [NUM_MASTERS-1:0]               grant_o
);

  localparam int MIW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SIW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wb_intercon: TIMEOUT_CYCLES must be at least 1");
  end

  state_e                 r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt, w_arb_grant;
  logic [MIW-1:0]         r_owner, w_owner_nxt, r_last, w_last_nxt, w_arb_idx;
  logic                   w_own_cyc, w_own_stb, w_hit, w_active, w_sel_ack, w_tmo_exp;
  logic [SIW-1:0]         w_hit_idx;
  logic [WB_ADDR_WIDTH-1:0] w_own_addr;

  wb_rr_arbiter #(.N(NUM_MASTERS), .IW(MIW)) u_arb (
    .i_req   (m_cyc_i),
    .i_last  (r_last),
    .o_grant (w_arb_grant)
  );

  always_comb begin
    w_arb_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_arb_grant[i]) w_arb_idx = MIW'(i);
    end
  end

  assign w_own_cyc  = m_cyc_i[r_owner];
  assign w_own_stb  = w_own_cyc & m_stb_i[r_owner];
  assign w_own_addr = m_addr_i[int'(r_owner)*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];

  assign s_addr_o = w_own_addr;
  assign s_data_o = m_data_i[int'(r_owner)*WB_DATA_WIDTH +: WB_DATA_WIDTH];
  assign s_sel_o  = m_sel_i[int'(r_owner)*WB_SEL_WIDTH +: WB_SEL_WIDTH];
  assign s_we_o   = m_we_i[r_owner];
  assign grant_o  = r_grant;

  // Descending scan: the last match assigned is the lowest slave index.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((w_own_addr & SLAVE_MASK[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH])
          == SLAVE_BASE[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH]) begin
        w_hit     = 1'b1;
        w_hit_idx = SIW'(i);
      end
    end
  end

  assign w_active  = (r_state == ST_OWNED) && w_own_stb && w_hit;
  assign w_sel_ack = s_ack_i[w_hit_idx];

  always_comb begin
    s_cyc_o  = '0;
    s_stb_o  = '0;
    m_ack_o  = '0;
    m_err_o  = '0;
    m_data_o = '0;
    if (w_active) begin
      s_cyc_o[w_hit_idx] = 1'b1;
      s_stb_o[w_hit_idx] = 1'b1;
      m_ack_o[r_owner]   = w_sel_ack;
      m_data_o[int'(r_owner)*WB_DATA_WIDTH +: WB_DATA_WIDTH] =
        s_data_i[int'(w_hit_idx)*WB_DATA_WIDTH +: WB_DATA_WIDTH];
    end
    if (r_state == ST_ERROR) m_err_o[r_owner] = 1'b1;
  end

`ifdef WB_INTERCON_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo, w_tmo_nxt;

  // Expires on the TIMEOUT_CYCLES-th consecutive un-acked strobe cycle.
  always_comb begin
    w_tmo_nxt = '0;
    w_tmo_exp = 1'b0;
    if (w_active && !w_sel_ack) begin
      if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) w_tmo_exp = 1'b1;
      else                                  w_tmo_nxt = r_tmo + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_tmo <= '0;
    else         r_tmo <= w_tmo_nxt;
  end
`else
  assign w_tmo_exp = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          w_state_nxt = ST_OWNED;
          w_grant_nxt = w_arb_grant;
          w_owner_nxt = w_arb_idx;
          w_last_nxt  = w_arb_idx;
        end
      end
      ST_OWNED: begin
        if (!w_own_cyc) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
        end else if ((w_own_stb && !w_hit) || w_tmo_exp) begin
          w_state_nxt = ST_ERROR;
        end
      end
      ST_ERROR: begin
        if (w_own_cyc) begin
          w_state_nxt = ST_OWNED;
        end else begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // Pointer resets to the top master so the first search begins at master 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_last  <= MIW'(NUM_MASTERS - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_intercon.sv
// tb_wb_intercon: directed vector table plus hand sequences for arbitration, errors, timeout and reset.
`default_nettype none
module tb_wb_intercon;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [63:0] m_addr_i = '0;
  logic [63:0] m_data_i = '0;
  logic [7:0]  m_sel_i = '0;
  logic [1:0]  m_we_i = '0, m_stb_i = '0, m_cyc_i = '0;
  logic [1:0]  m_ack_o, m_err_o, grant_o;
  logic [63:0] m_data_o;
  logic [31:0] s_addr_o, s_data_o;
  logic [3:0]  s_sel_o, s_stb_o, s_cyc_o;
  logic        s_we_o;
  logic [3:0]  s_ack_i = '0;
  logic [127:0] s_data_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  wb_intercon dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_sel_i(m_sel_i),
    .m_we_i(m_we_i), .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_data_o(m_data_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i), .s_data_i(s_data_i),
    .grant_o(grant_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] addr);
    m_cyc_i[m] = cyc;
    m_stb_i[m] = stb;
    m_we_i[m]  = we;
    m_addr_i[m*32 +: 32] = addr;
    m_data_i[m*32 +: 32] = 32'h1234_0000 + 32'(m);
    m_sel_i[m*4 +: 4]    = 4'hF;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
  endtask

  task automatic default_slave_data();
    for (int i = 0; i < 4; i++) s_data_i[i*32 +: 32] = 32'hA000_0000 + 32'(i);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        stb;
    logic [3:0]  ack;
    logic [3:0]  exp_stb;
    logic [1:0]  exp_ack;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit stb_ok;

    vecs[0] = '{32'h0000_0040, 1'b1, 4'b0001, 4'b0001, 2'b01, 32'hA000_0000};
    vecs[1] = '{32'h0001_0010, 1'b1, 4'b0000, 4'b0010, 2'b00, 32'hA000_0001};
    vecs[2] = '{32'h0001_0010, 1'b1, 4'b1000, 4'b0010, 2'b00, 32'hA000_0001};
    vecs[3] = '{32'h0001_0010, 1'b1, 4'b0010, 4'b0010, 2'b01, 32'hA000_0001};
    vecs[4] = '{32'h0001_0104, 1'b1, 4'b0100, 4'b0100, 2'b01, 32'hA000_0002};
    vecs[5] = '{32'h0002_FFFC, 1'b1, 4'b1000, 4'b1000, 2'b01, 32'hA000_0003};
    vecs[6] = '{32'h0000_FFFF, 1'b1, 4'b0001, 4'b0001, 2'b01, 32'hA000_0000};
    vecs[7] = '{32'h0001_0200, 1'b0, 4'b1111, 4'b0000, 2'b00, 32'h0000_0000};
    vecs[8] = '{32'h0002_0000, 1'b0, 4'b1000, 4'b0000, 2'b00, 32'h0000_0000};

    default_slave_data();

    // Reset state
    step();
    #1;
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_s_stb", {s_cyc_o, s_stb_o}, 8'h00);
    chk("rst_m_ack", m_ack_o, 2'b00);
    chk("rst_m_err", m_err_o, 2'b00);
    rst_ni = 1'b1;

    // Single read by master 0
    step();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0040);
    #1;
    chk("rd_grant_pre", grant_o, 2'b00);
    step();
    #1;
    chk("rd_grant", grant_o, 2'b01);
    chk("rd_s_stb", s_stb_o, 4'b0001);
    chk("rd_ack_wait", m_ack_o, 2'b00);
    s_ack_i = 4'b0001;
    s_data_i[31:0] = 32'hDEAD_BEEF;
    #1;
    chk("rd_ack", m_ack_o, 2'b01);
    chk("rd_data", m_data_o[31:0], 32'hDEAD_BEEF);
    chk("rd_err", m_err_o, 2'b00);
    step();
    s_ack_i = '0;
    default_slave_data();
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    #1;
    chk("rd_idle_grant", grant_o, 2'b00);

    // Decode / routing table, master 0 owning the bus
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    for (int v = 0; v < 9; v++) begin
      step();
      set_m(0, 1'b1, vecs[v].stb, 1'b0, vecs[v].addr);
      s_ack_i = vecs[v].ack;
      #1;
      chk($sformatf("vec%0d_s_stb", v), {s_cyc_o, s_stb_o}, {vecs[v].exp_stb, vecs[v].exp_stb});
      chk($sformatf("vec%0d_m_ack", v), m_ack_o, vecs[v].exp_ack);
      chk($sformatf("vec%0d_m_data", v), m_data_o, {32'h0, vecs[v].exp_data});
      chk($sformatf("vec%0d_m_err", v), m_err_o, 2'b00);
    end
    step();
    s_ack_i = '0;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();

    // Unmapped write by master 1
    set_m(1, 1'b1, 1'b1, 1'b1, 32'h0003_0000);
    step();
    #1;
    chk("miss_grant", grant_o, 2'b10);
    chk("miss_s_stb", {s_cyc_o, s_stb_o}, 8'h00);
    chk("miss_err_pre", m_err_o, 2'b00);
    step();
    #1;
    chk("miss_err", m_err_o, 2'b10);
    chk("miss_ack", m_ack_o, 2'b00);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    #1;
    chk("miss_err_end", m_err_o, 2'b00);
    chk("miss_idle", grant_o, 2'b00);

    // Non-acking slave 2
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0001_0104);
    stb_ok = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      #1;
      if (s_stb_o !== 4'b0100 || m_err_o !== 2'b00) stb_ok = 1'b0;
    end
    chk("tmo_16_stb_cycles", {63'h0, stb_ok}, 64'h1);
    step();
    #1;
`ifdef WB_INTERCON_TIMEOUT_EN
    chk("tmo_s_stb", s_stb_o, 4'b0000);
    chk("tmo_err", m_err_o, 2'b01);
`else
    chk("tmo_s_stb", s_stb_o, 4'b0100);
    chk("tmo_err", m_err_o, 2'b00);
`endif
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    step();
    #1;
    chk("tmo_idle", grant_o, 2'b00);

    // Round-robin contention after reset
    do_reset();
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h0);
    set_m(1, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    #1;
    chk("rr_first", grant_o, 2'b01);
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0040);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0040);
    s_ack_i = 4'b0001;
    #1;
    chk("rr_owner_ack", m_ack_o, 2'b01);
    step();
    s_ack_i = '0;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
    set_m(1, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    #1;
    chk("rr_gap", grant_o, 2'b00);
    step();
    #1;
    chk("rr_second", grant_o, 2'b10);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h0001_0010);
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0040);
    s_ack_i = 4'b0001;
    #1;
    chk("rr_holdoff_ack", m_ack_o, 2'b00);
    chk("rr_holdoff_stb", s_stb_o, 4'b0010);
    step();
    s_ack_i = '0;
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0);
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    #1;
    chk("rr_gap2", grant_o, 2'b00);
    step();
    #1;
    chk("rr_third", grant_o, 2'b01);
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    step();

    // Reset asserted mid-transaction
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0040);
    step();
    #1;
    chk("mid_grant", grant_o, 2'b10);
    chk("mid_s_stb", s_stb_o, 4'b0001);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_grant", grant_o, 2'b00);
    chk("mid_rst_sel", {s_cyc_o, s_stb_o}, 8'h00);
    chk("mid_rst_term", {m_ack_o, m_err_o}, 4'h0);
    s_ack_i = 4'b0001;
    step();
    #1;
    chk("mid_rst_hold", {m_ack_o, m_err_o}, 4'h0);
    rst_ni = 1'b1;
    s_ack_i = '0;
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    #1;
    chk("mid_after_grant", grant_o, 2'b01);
    chk("mid_after_term", {m_ack_o, m_err_o}, 4'h0);
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_intercon.md
WB_INTERCON -- requirements
Module: wb_intercon

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2: number of Wishbone masters.
REQ-002 SHALL have parameter NUM_SLAVES, default 4: number of Wishbone slaves.
REQ-003 SHALL have parameters WB_ADDR_WIDTH 32, WB_DATA_WIDTH 32, WB_SEL_WIDTH 4: bus widths.
REQ-004 SHALL have parameters SLAVE_BASE and SLAVE_MASK, each NUM_SLAVES*WB_ADDR_WIDTH bits, slot i at bits [i*AW +: AW]; default bases 0x0000_0000, 0x0001_0000, 0x0001_0100, 0x0002_0000; default masks 0xFFFF_0000, 0xFFFF_FF00, 0xFFFF_FF00, 0xFFFF_0000.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 16: slave ack timeout.
REQ-006 clk_i  in  1  single clock, all state on rising edge.
REQ-007 rst_ni  in  1  asynchronous, active-low reset.
REQ-008 m_addr_i/m_data_i/m_sel_i  in  NUM_MASTERS*AW / *DW / *SW  per-master request fields.
REQ-009 m_we_i/m_stb_i/m_cyc_i  in  NUM_MASTERS  per-master control.
REQ-010 m_ack_o/m_err_o  out  NUM_MASTERS  per-master termination; m_data_o  out  NUM_MASTERS*DW  read data.
REQ-011 s_addr_o/s_data_o/s_sel_o/s_we_o  out  AW/DW/SW/1  shared slave request bus, driven from granted master.
REQ-012 s_stb_o/s_cyc_o  out  NUM_SLAVES  per-slave select; s_ack_i  in  NUM_SLAVES; s_data_i  in  NUM_SLAVES*DW.
REQ-013 grant_o  out  NUM_MASTERS  one-hot current owner, zero when idle.

Function
REQ-014 States SHALL be IDLE, OWNED, ERROR.
REQ-015 In IDLE, if any m_cyc_i set, SHALL register a round-robin grant next edge and enter OWNED; search starts at last owner+1, modulo NUM_MASTERS.
REQ-016 In OWNED, owner keeps grant while its m_cyc_i is high; other masters' requests are held off (ack/err 0).
REQ-017 Owner dropping m_cyc_i SHALL return to IDLE next edge; one idle cycle between successive owners.
REQ-018 Decode: slave i hit when (addr & MASK_i) == BASE_i; multiple hits, lowest index wins.
REQ-019 Hit with owner stb: s_cyc_o[i]/s_stb_o[i] follow owner cyc/stb combinationally; all other slave selects 0.
REQ-020 m_ack_o[owner] = s_ack_i[i] & owner stb, combinational; m_data_o[owner] = s_data_i[i]; non-owner data 0.
REQ-021 Acks from non-selected slaves SHALL be ignored.
REQ-022 Decode miss with owner stb: no slave select; enter ERROR; m_err_o[owner] high exactly one cycle, then OWNED if cyc still high, else IDLE.
REQ-023 m_ack_o and m_err_o SHALL never be high together for the same master.

Reset
REQ-024 Assertion of rst_ni SHALL immediately force IDLE, grant_o 0, round-robin pointer to master 0, timeout counter 0, all s_stb_o/s_cyc_o/m_ack_o/m_err_o 0, including mid-transaction.
REQ-025 First arbitration after reset release SHALL favour master 0.

Configuration
REQ-026 With WB_INTERCON_TIMEOUT_EN defined: counter counts owner-stb cycles without ack, clears on ack or stb low; on reaching TIMEOUT_CYCLES, slave selects drop and ERROR entered (REQ-022 error pulse).
REQ-027 Without WB_INTERCON_TIMEOUT_EN: no counter logic; a non-acking slave holds the bus indefinitely.

Structure
REQ-028 Package wb_intercon_pkg SHALL hold the state enum and default width/address constants.
REQ-029 Round-robin arbitration SHALL be sub-module wb_rr_arbiter (request vector, last-owner pointer in, one-hot grant out).

Verification
REQ-030 Master 0 read 0x0000_0040, slave 0 acks next cycle with 0xDEADBEEF -> grant_o=01 one cycle after cyc, s_stb_o=0001, m_data_o[0]=0xDEADBEEF with m_ack_o[0].
REQ-031 Both masters assert cyc same cycle after reset -> master 0 granted; after release, master 1 granted after one idle cycle; repeat -> master 0 again.
REQ-032 Master 1 write 0x0003_0000 (unmapped) -> no s_stb_o, m_err_o[1] single-cycle pulse, m_ack_o[1] stays 0.
REQ-033 With WB_INTERCON_TIMEOUT_EN, slave 2 never acks access to 0x0001_0104 -> after 16 stb cycles s_stb_o[2] drops, m_err_o[0] pulses; without macro stb stays high.
REQ-034 rst_ni low during OWNED with stb pending -> all outputs 0 same cycle, no ack/err later; after release master 0 wins contention.
REQ-035 Spurious s_ack_i[3] during slave 1 access -> ignored; only s_ack_i[1] terminates.
